// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch state encoding and opcode constants
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_COMP = 4'h6;
    localparam logic [3:0] OP_COPY = 4'h7;
    localparam logic [3:0] OP_CPYC = 4'h8;
    localparam logic [3:0] OP_LOAD = 4'h9;
    localparam logic [3:0] OP_STOR = 4'hA;
    localparam logic [3:0] OP_PUSH = 4'hB;
    localparam logic [3:0] OP_POP  = 4'hC;
    localparam logic [3:0] OP_JMPL = 4'hD;
    localparam logic [3:0] OP_JMPE = 4'hE;
    localparam logic [3:0] OP_JUMP = 4'hF;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pc, ir, imem handshake, retire count
module fetch_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rstN,
    input  logic               run,
    output logic               imemReq,
    output logic [PC_W-1:0]    imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [3:0]         opcode,
    output logic [11:0]        instrData,
    output logic               instrValid,
    input  logic               exDone,
    input  logic               jumpTaken,
    input  logic [PC_W-1:0]    jumpTarget,
    input  logic               haltIn,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   instrCount
);

    fetch_state_t       state, state_nxt;
    logic [PC_W-1:0]    pc_q, pc_nxt;
    logic [INSTR_W-1:0] ir_q, ir_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    // State register; async reset returns to IDLE so an in-flight request drops at once
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: program counter, instruction register, retired count
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc_q  <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_nxt;
            ir_q  <= ir_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Next-state and datapath update; halt outranks exDone in ISSUE
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        cnt_nxt   = cnt_q;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imemAck) begin
                    ir_nxt    = imemData;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (haltIn) begin
                    state_nxt = S_HALTED;
                end else if (exDone) begin
                    pc_nxt    = jumpTaken ? jumpTarget : pc_q + 1'b1;
                    cnt_nxt   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs come only from state and registers, never straight from inputs
    assign imemReq    = (state == S_FETCH);
    assign imemAddr   = pc_q;
    assign instrValid = (state == S_ISSUE);
    assign halted     = (state == S_HALTED);
    assign opcode     = ir_q[INSTR_W-1 -: 4];
    assign instrData  = ir_q[11:0];
    assign pc         = pc_q;
    assign instrCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rstN;
    logic               run;
    logic               imemReq;
    logic [PC_W-1:0]    imemAddr;
    logic               imemAck;
    logic [INSTR_W-1:0] imemData;
    logic [3:0]         opcode;
    logic [11:0]        instrData;
    logic               instrValid;
    logic               exDone;
    logic               jumpTaken;
    logic [PC_W-1:0]    jumpTarget;
    logic               haltIn;
    logic               halted;
    logic [PC_W-1:0]    pc;
    logic [CNT_W-1:0]   instrCount;

    fetch_unit dut (
        .clk        (clk),
        .rstN       (rstN),
        .run        (run),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .opcode     (opcode),
        .instrData  (instrData),
        .instrValid (instrValid),
        .exDone     (exDone),
        .jumpTaken  (jumpTaken),
        .jumpTarget (jumpTarget),
        .haltIn     (haltIn),
        .halted     (halted),
        .pc         (pc),
        .instrCount (instrCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [INSTR_W-1:0] imem [0:1023];
    int  ws        = 0;
    int  wcnt      = 0;
    bit  stray_ack = 1'b0;
    bit  ex_auto   = 1'b0;
    int  ex_delay  = 1;
    bit  halt_en   = 1'b0;
    int  issue_cyc = 0;
    int  n_ret     = 0;
    logic [PC_W-1:0]    m_pc  = '0;
    logic [CNT_W-1:0]   m_cnt = '0;
    logic [PC_W-1:0]    q_addr  [$];
    logic [INSTR_W-1:0] q_instr [$];
    bit  prev_req = 1'b0;
    bit  prev_val = 1'b0;

    // Instruction memory with programmable wait states and optional stray acks
    always @(negedge clk) begin
        if (imemReq && wcnt == ws) begin
            imemAck  = 1'b1;
            imemData = imem[imemAddr];
            q_instr.push_back(imem[imemAddr]);
            wcnt     = 0;
        end else begin
            imemAck  = stray_ack;
            imemData = 16'hFFFF;
            if (imemReq) wcnt++;
            else         wcnt = 0;
        end
    end

    // Decoder/execute model: raises haltIn on OP_HALT, retires after ex_delay cycles
    always @(negedge clk) begin
        exDone = 1'b0;
        haltIn = 1'b0;
        if (rstN && instrValid) begin
            issue_cyc++;
            if (halt_en && opcode == OP_HALT) haltIn = 1'b1;
            if (ex_auto && issue_cyc >= ex_delay + 1) begin
                exDone = 1'b1;
                if (!haltIn) begin
                    m_pc  = jumpTaken ? jumpTarget : m_pc + 1'b1;
                    m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1'b1;
                    n_ret++;
                    q_addr.push_back(m_pc);
                end
            end
        end else begin
            issue_cyc = 0;
        end
    end

    // Scoreboard: compare fetch address and issued fields against queued expectations
    always @(posedge clk) begin
        logic [PC_W-1:0]    ea;
        logic [INSTR_W-1:0] ei;
        #1;
        if (!rstN) begin
            prev_req = 1'b0;
            prev_val = 1'b0;
        end else begin
            if (imemReq && !prev_req) begin
                if (q_addr.size() == 0) begin
                    check("fetch_unexpected", q_addr.size(), 1);
                end else begin
                    ea = q_addr.pop_front();
                    check("fetch_addr", imemAddr, ea);
                end
            end
            if (instrValid && !prev_val) begin
                if (q_instr.size() == 0) begin
                    check("issue_unexpected", q_instr.size(), 1);
                end else begin
                    ei = q_instr.pop_front();
                    check("issue_opcode", opcode, ei[15:12]);
                    check("issue_data", instrData, ei[11:0]);
                end
            end
            prev_req = imemReq;
            prev_val = instrValid;
        end
    end

    task automatic wait_ret(input int target, input int budget);
        int k = 0;
        while (n_ret < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("retire_wait", n_ret, target);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rstN = 1'b0; run = 1'b0; imemAck = 1'b0; imemData = '0;
        exDone = 1'b0; jumpTaken = 1'b0; jumpTarget = '0; haltIn = 1'b0;
        for (int i = 0; i < 1024; i++) imem[i] = {4'(1 + i % 15), 12'(i * 37)};
        imem[0]      = 16'h3123;
        imem[1]      = 16'h4321;
        imem[10'h100] = 16'h0000;

        // Reset state and idle hold
        repeat (3) @(posedge clk);
        @(negedge clk); rstN = 1'b1;
        tick();
        check("rst_req", imemReq, 0);
        check("rst_addr", imemAddr, 0);
        check("rst_opcode", opcode, 0);
        check("rst_data", instrData, 0);
        check("rst_valid", instrValid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_count", instrCount, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_req", imemReq, 0);
            check("idle_valid", instrValid, 0);
        end

        // Sequential fetch with two wait states
        ws = 2; ex_delay = 1; ex_auto = 1'b1;
        q_addr.push_back(10'd0);
        run = 1'b1;
        tick();
        check("run_to_fetch", imemReq, 1);
        run = 1'b0;
        wait_ret(2, 40);
        tick();
        check("count_seq", instrCount, 2);

        // Jump without exDone is ignored, then taken jump
        wait_ret(5, 80);
        ex_auto = 1'b0;
        for (int k = 0; k < 20 && !instrValid; k++) tick();
        check("issue_at5", instrValid, 1);
        jumpTaken = 1'b1; jumpTarget = 10'h2A0;
        repeat (3) tick();
        check("nojump_pc", pc, 5);
        check("nojump_valid", instrValid, 1);
        ex_auto = 1'b1;
        wait_ret(6, 20);
        check("jump_pc", pc, 10'h2A0);

        // Wrap-around from 1023
        jumpTarget = 10'h3FF;
        wait_ret(7, 40);
        jumpTaken = 1'b0;
        wait_ret(8, 40);
        check("wrap_pc", pc, 0);
        check("wrap_count", instrCount, 8);

        // Halt outranks a simultaneous exDone
        jumpTaken = 1'b1; jumpTarget = 10'h100;
        wait_ret(9, 40);
        jumpTaken = 1'b0; ex_delay = 0; halt_en = 1'b1;
        for (int k = 0; k < 20 && !halted; k++) tick();
        check("halt_set", halted, 1);
        check("halt_pc", pc, 10'h100);
        check("halt_count", instrCount, 9);
        check("halt_opcode", opcode, OP_HALT);
        check("halt_valid", instrValid, 0);
        run = 1'b1; stray_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halted_req", imemReq, 0);
            check("halted_sticky", halted, 1);
        end
        stray_ack = 1'b0; run = 1'b0;
        check("halted_pc_hold", pc, 10'h100);
        check("halted_count_hold", instrCount, 9);
        check("halted_retire", n_ret, 9);

        // Reset during a fetch drops the request immediately
        ex_auto = 1'b0; halt_en = 1'b0;
        @(negedge clk); rstN = 1'b0;
        @(negedge clk); rstN = 1'b1;
        m_pc = '0; m_cnt = '0;
        tick();
        check("rerst_halted", halted, 0);
        ws = 5;
        q_addr.push_back(10'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("refetch_req", imemReq, 1);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        check("midfetch_rst_req", imemReq, 0);
        check("midfetch_rst_count", instrCount, 0);
        @(negedge clk); rstN = 1'b1;
        tick();

        // Counter saturation from a preloaded 0xFFFE
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        base = n_ret;
        ws = 0; ex_delay = 0; ex_auto = 1'b1;
        q_addr.push_back(10'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("zero_wait_issue", instrValid, 1);
        wait_ret(base + 1, 20);
        check("count_ffff", instrCount, 16'hFFFF);
        wait_ret(base + 3, 40);
        tick();
        check("count_sat", instrCount, 16'hFFFF);
        ex_auto = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage directly upstream of the control decoder.
- Owns the 10-bit program counter and the 16-bit instruction register.
- Fetches from instruction memory over a req/ack handshake and presents opcode and operand fields to the decoder.
- Advances the PC sequentially or to a jump target reported by execute; stops permanently on halt.

## Interface
- PC_W, 10, program counter / instruction address width (matches 10-bit jump target)
- INSTR_W, 16, instruction width (4-bit opcode + 12-bit operand)
- CNT_W, 16, retired-instruction counter width
- clk  in  1  single clock, all state on rising edge
- rstN  in  1  asynchronous, active-low reset
- run  in  1  level; leaves IDLE when high
- imemReq  out  1  instruction memory read request
- imemAddr  out  PC_W  read address, equals pc
- imemAck  in  1  read data valid this cycle
- imemData  in  INSTR_W  instruction word, sampled when imemReq && imemAck
- opcode  out  4  ir[15:12], to decoder
- instrData  out  12  ir[11:0], to decoder dataIn
- instrValid  out  1  ir holds an instruction being executed
- exDone  in  1  execute finished current instruction (one-cycle pulse)
- jumpTaken  in  1  qualified with exDone; next pc = jumpTarget
- jumpTarget  in  PC_W  jump destination
- haltIn  in  1  decoder halt flag for current instruction
- halted  out  1  unit is in HALTED
- pc  out  PC_W  current program counter
- instrCount  out  CNT_W  retired instruction count

## Operation

States: IDLE, FETCH, ISSUE, HALTED. Encoding comes from the package.

- **IDLE**
  - imemReq=0, instrValid=0.
  - Goes to FETCH when run=1.
- **FETCH**
  - imemReq=1 and imemAddr=pc, held stable until ack.
  - On imemAck: ir<=imemData, go to ISSUE.
  - run is ignored once FETCH is entered.
- **ISSUE**
  - instrValid=1; opcode/instrData driven from ir; imemReq=0.
  - If haltIn=1: go to HALTED. pc and instrCount are unchanged, and any exDone in that cycle is ignored. Halt has priority.
  - Else if exDone=1:
    - instrCount increments, saturating at all-ones.
    - pc <= jumpTaken ? jumpTarget : pc+1, with pc+1 wrapping 1023->0.
    - Go to FETCH.
  - jumpTaken without exDone is ignored.
- **HALTED**
  - imemReq=0, instrValid=0, halted=1.
  - Sticky; only rstN exits.
  - ir keeps the halt instruction.
- imemAck is ignored whenever imemReq=0.
- Width rules: pc arithmetic is modulo 2^PC_W; jumpTarget is used as-is, with no sign handling.

## Timing
- Reset (async assert, synchronous release) gives:
  - state=IDLE, pc=0, ir=0, instrCount=0.
  - imemReq=0, instrValid=0, halted=0.
  - opcode=0, instrData=0, imemAddr=0.
- Reset mid-fetch drops imemReq immediately; any ack still outstanding is discarded.
- run=1 in cycle N: FETCH in N+1 with imemReq=1.
- Zero-wait memory (ack in the first request cycle): ISSUE in the next cycle. A fetch takes 1 + wait-state cycles.
- All outputs are registered or derived from state/ir; there is no combinational path from inputs to outputs.
- exDone in ISSUE cycle M: FETCH in M+1 with the new pc on imemAddr. Minimum back-to-back rate is one instruction per 2 cycles.
- haltIn in cycle M: halted=1 from M+1.

## Structure
- Shared package cpu_pkg holds:
  - PC_W, INSTR_W, CNT_W.
  - Fetch state encoding.
  - Opcode constants OP_HALT=4'h0, OP_AND=4'h1, OP_OR=4'h2, OP_ADD=4'h3, OP_SUB=4'h4, OP_ADDI=4'h5, OP_COMP=4'h6, OP_COPY=4'h7, OP_CPYC=4'h8, OP_LOAD=4'h9, OP_STOR=4'hA, OP_PUSH=4'hB, OP_POP=4'hC, OP_JMPL=4'hD, OP_JMPE=4'hE, OP_JUMP=4'hF.
- Single module; no sub-module is warranted.

## Test plan
- **Reset values:** hold rstN=0 then release with run=0 -> all outputs 0, state stays IDLE for 10 cycles. Assert rstN=0 during FETCH -> imemReq=0 in the same cycle.
- **Sequential fetch:** memory 0x3123 at 0, 0x4321 at 1, ack with 2 wait states, exDone 1 cycle after each instrValid -> imemAddr 0 then 1; opcode/instrData 3/0x123 then 4/0x321; instrCount=2.
- **Jump:** in ISSUE at pc=5, pulse exDone with jumpTaken=1, jumpTarget=0x2A0 -> next imemAddr=0x2A0. Separately, jumpTaken=1 without exDone -> pc stays 5.
- **Wrap-around:** pc=1023 and exDone without jump -> next imemAddr=0.
- **Halt priority:** fetch 0x0000 (haltIn=1) and assert exDone in the same cycle -> halted=1 next cycle, pc unchanged, instrCount unchanged, imemReq=0 for 20 cycles while run=1, and stray imemAck pulses are ignored.
- **Counter saturation:** preload instrCount=0xFFFE via 0xFFFE retirements (or force), then retire 3 more -> instrCount holds at 0xFFFF.
